if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage. Owns the PC, issues word fetches to instruction memory over a req/gnt/rvalid handshake, and presents instruction, PC and PC+4 to the IF/ID boundary. Honours the decode-stage stall and a redirect (taken branch, j/jal, jr/jalr) resolved downstream. A 1-entry skid buffer absorbs a fetch response that returns while decode is stalled.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
ADDR_W, 32, PC/address width.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  reset, synchronous, active-low.
stall  in  1  decode not accepting; output held while high.
redirect  in  1  load redirect_pc, squash everything younger.
redirect_pc  in  32  new fetch address.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch word address (bits[1:0]=0).
imem_gnt  in  1  memory accepts request this cycle.
imem_rvalid  in  1  response data valid.
imem_rdata  in  32  fetched instruction.
IF_valid  out  1  IF_inst/IF_pc hold a live instruction.
IF_inst  out  32  instruction to decode.
IF_pc  out  32  address of IF_inst.
IF_pc4  out  32  IF_pc + 4.

Behaviour:
- Reset (rst=0 at edge): pc=RESET_PC; IF_valid=0; IF_inst=0 (NOP); IF_pc=0; IF_pc4=4; skid empty; discard=0; state=IDLE; imem_req=0. Reset mid-fetch abandons the outstanding request; a later rvalid is ignored because state is IDLE/REQ.
- States: IDLE -> REQ (one cycle after reset release). REQ: imem_req=1, imem_addr=pc; if imem_gnt -> WAIT, pc<=pc+4. WAIT: imem_req=0; on imem_rvalid -> REQ if room remains after capture, else FULL. FULL: no request; -> REQ when skid drains.
- At most one outstanding request. No request while skid full.
- Consume: the output register is consumed at an edge where IF_valid=1 and stall=0.
- Capture on rvalid (discard=0): if output empty or consumed this edge -> load output (IF_pc = address of that fetch, IF_pc4 = +4, wrap mod 2^32), else -> skid. If output consumed and skid full, skid moves to output and response enters skid in the same edge.
- Room for a new REQ = skid empty after this edge.
- Redirect (highest priority, overrides stall): pc<=redirect_pc with bits[1:0] forced 0; IF_valid<=0, IF_inst<=0; skid cleared. If state WAIT: discard<=1, stay WAIT; the matching rvalid is dropped, discard<=0, -> REQ. If state REQ with gnt same cycle: grant treated as issued, discard<=1, -> WAIT. Otherwise -> REQ next cycle with new pc.
- Redirect in same cycle as rvalid with discard=0: response dropped, -> REQ.
- stall=1: IF_valid/IF_inst/IF_pc/IF_pc4 stable; fetch may continue into skid only.
- pc+4 wraps at 32'hFFFF_FFFC -> 0.
- Throughput with 1-cycle rvalid latency and no stall: one instruction every 2 cycles (REQ, WAIT).

Test Plan:
- Reset release, gnt=1, rvalid one cycle after gnt, rdata 32'h2408_0005 -> first imem_addr=32'h0000_3000; IF_valid=1 with IF_inst=32'h2408_0005, IF_pc=0x3000, IF_pc4=0x3004; next addr 0x3004.
- stall=1 held 6 cycles -> output frozen at 0x3004 instruction; 0x3008 response lands in skid; no further imem_req; release stall -> 0x3008 presented next cycle, fetch of 0x300C starts.
- redirect=1, redirect_pc=32'h0000_3101 while in WAIT -> returning rvalid dropped, IF_valid=0 that cycle, next imem_addr=0x3100.
- redirect and stall both high with skid full -> output and skid cleared, next IF_pc=redirect_pc.
- gnt withheld 5 cycles -> imem_req and imem_addr (0x3000) stable until gnt; pc advances once only.
- rst=0 asserted during WAIT, later rvalid arrives -> ignored; after release first fetch is RESET_PC; pc=0xFFFFFFFC fetch -> next addr 0x0, IF_pc4=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ============================================================================
//  Module   : if_fetch_stage
//  Brief    : Instruction-fetch stage. Owns the PC, issues word fetches over a
//             req/gnt/rvalid handshake and presents inst/pc/pc+4 to decode.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              IF_valid,
    output logic [31:0]       IF_inst,
    output logic [ADDR_W-1:0] IF_pc,
    output logic [ADDR_W-1:0] IF_pc4
);

    localparam logic [ADDR_W-1:0] c_word     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_low_mask = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_rst_pc   = RESET_PC[ADDR_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_discard;

    logic              r_out_valid;
    logic [31:0]       r_out_inst;
    logic [ADDR_W-1:0] r_out_pc;
    logic [ADDR_W-1:0] r_out_pc4;

    logic              r_skid_valid;
    logic [31:0]       r_skid_inst;
    logic [ADDR_W-1:0] r_skid_pc;

    logic w_consume;
    logic w_load_out;
    logic w_rsp_take;
    logic w_skid_next;

    always_comb begin
        w_consume   = r_out_valid && !stall;
        w_load_out  = !r_out_valid || w_consume;
        w_rsp_take  = (r_state == S_WAIT) && imem_rvalid && !r_discard;
        w_skid_next = r_skid_valid;
        if (w_rsp_take)
            w_skid_next = r_skid_valid || !w_load_out;
        else if (w_load_out)
            w_skid_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pc         <= c_rst_pc;
            r_fetch_pc   <= '0;
            r_discard    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_inst   <= '0;
            r_out_pc     <= '0;
            r_out_pc4    <= c_word;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= '0;
            r_skid_pc    <= '0;
        end else if (redirect) begin
            // Squash all younger work; an in-flight response must still be absorbed.
            r_pc         <= redirect_pc & ~c_low_mask;
            r_out_valid  <= 1'b0;
            r_out_inst   <= '0;
            r_skid_valid <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_discard <= 1'b0;
                        r_state   <= S_REQ;
                    end else begin
                        r_discard <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        r_discard <= 1'b1;
                        r_state   <= S_WAIT;
                    end else begin
                        r_state   <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end else begin
            if (w_rsp_take) begin
                if (w_load_out) begin
                    r_out_valid <= 1'b1;
                    if (r_skid_valid) begin
                        r_out_inst  <= r_skid_inst;
                        r_out_pc    <= r_skid_pc;
                        r_out_pc4   <= r_skid_pc + c_word;
                        r_skid_inst <= imem_rdata;
                        r_skid_pc   <= r_fetch_pc;
                    end else begin
                        r_out_inst  <= imem_rdata;
                        r_out_pc    <= r_fetch_pc;
                        r_out_pc4   <= r_fetch_pc + c_word;
                    end
                end else begin
                    r_skid_inst <= imem_rdata;
                    r_skid_pc   <= r_fetch_pc;
                end
            end else if (w_load_out && r_skid_valid) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= r_skid_inst;
                r_out_pc    <= r_skid_pc;
                r_out_pc4   <= r_skid_pc + c_word;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
            r_skid_valid <= w_skid_next;

            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (imem_gnt) begin
                        r_fetch_pc <= r_pc;
                        r_pc       <= r_pc + c_word;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_discard <= 1'b0;
                        r_state   <= w_skid_next ? S_FULL : S_REQ;
                    end
                end
                S_FULL: begin
                    if (!w_skid_next)
                        r_state <= S_REQ;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req  = (r_state == S_REQ);
    assign imem_addr = r_pc;
    assign IF_valid  = r_out_valid;
    assign IF_inst   = r_out_inst;
    assign IF_pc     = r_out_pc;
    assign IF_pc4    = r_out_pc4;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Brief    : Directed bench for if_fetch_stage with a one-deep memory model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        IF_valid;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;
    logic [31:0] IF_pc4;

    int checks   = 0;
    int failures = 0;

    // memory model state
    logic        gnt_en;
    logic        rsp_en;
    logic        pending;
    logic [31:0] paddr;

    if_fetch_stage #(
        .RESET_PC (32'h0000_3000),
        .ADDR_W   (32)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .IF_valid    (IF_valid),
        .IF_inst     (IF_inst),
        .IF_pc       (IF_pc),
        .IF_pc4      (IF_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2408_0005 + a - 32'h0000_3000;
    endfunction

    // Advance one rising edge, then update the memory-side inputs 1 ns later.
    task automatic tick();
        logic        fire;
        logic        deliver;
        logic [31:0] a;
        fire    = imem_req && imem_gnt;
        deliver = imem_rvalid;
        a       = imem_addr;
        @(posedge clk);
        #1;
        if (deliver) pending = 1'b0;
        if (fire) begin
            pending = 1'b1;
            paddr   = a;
        end
        imem_gnt    = gnt_en;
        imem_rvalid = pending && rsp_en;
        imem_rdata  = pending ? mem_word(paddr) : 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        gnt_en = 1'b1; rsp_en = 1'b1; pending = 1'b0; paddr = '0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

        tick(); tick();
        check("rst_valid", 32'(IF_valid), 32'd0);
        check("rst_inst",  IF_inst, 32'h0);
        check("rst_pc",    IF_pc,   32'h0);
        check("rst_pc4",   IF_pc4,  32'h4);
        check("rst_req",   32'(imem_req), 32'd0);

        // first fetch
        rst = 1'b1;
        tick();
        check("first_req",  32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0000_3000);
        tick();
        check("wait_req", 32'(imem_req), 32'd0);
        tick();
        check("first_valid", 32'(IF_valid), 32'd1);
        check("first_inst",  IF_inst, 32'h2408_0005);
        check("first_pc",    IF_pc,   32'h0000_3000);
        check("first_pc4",   IF_pc4,  32'h0000_3004);
        check("next_addr",   imem_addr, 32'h0000_3004);
        tick(); tick();
        check("i3004_inst", IF_inst, 32'h2408_0009);

        // stall: 0x3008 response goes to the skid, fetch stops
        stall = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check("stall_req",  32'(imem_req), 32'd0);
            check("stall_inst", IF_inst, 32'h2408_0009);
            check("stall_pc",   IF_pc,   32'h0000_3004);
            tick();
        end
        check("stall_req_end", 32'(imem_req), 32'd0);
        stall = 1'b0;
        tick();
        check("drain_inst", IF_inst, 32'h2408_000D);
        check("drain_pc",   IF_pc,   32'h0000_3008);
        check("drain_req",  32'(imem_req), 32'd1);
        check("drain_addr", imem_addr, 32'h0000_300C);

        // redirect while waiting: stale response dropped
        rsp_en = 1'b0;
        tick();
        check("rd_wait_req", 32'(imem_req), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_3101; rsp_en = 1'b1;
        tick();
        redirect = 1'b0;
        check("rd_valid0", 32'(IF_valid), 32'd0);
        check("rd_still_wait", 32'(imem_req), 32'd0);
        tick();
        check("rd_drop_valid", 32'(IF_valid), 32'd0);
        check("rd_addr", imem_addr, 32'h0000_3100);
        check("rd_req",  32'(imem_req), 32'd1);
        tick(); tick();
        check("rd_inst", IF_inst, 32'h2408_0105);
        check("rd_pc",   IF_pc,   32'h0000_3100);

        // redirect + stall with full skid
        stall = 1'b1;
        tick(); tick();
        check("full_req", 32'(imem_req), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_3200;
        tick();
        redirect = 1'b0; stall = 1'b0;
        check("rs_valid", 32'(IF_valid), 32'd0);
        check("rs_inst",  IF_inst, 32'h0);
        check("rs_addr",  imem_addr, 32'h0000_3200);
        tick(); tick();
        check("rs_pc",   IF_pc,   32'h0000_3200);
        check("rs_inst2", IF_inst, 32'h2408_0205);

        // grant withheld
        gnt_en = 1'b0; imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("nogt_req",  32'(imem_req), 32'd1);
            check("nogt_addr", imem_addr, 32'h0000_3204);
        end
        gnt_en = 1'b1; imem_gnt = 1'b1;
        tick();
        check("gt_wait", 32'(imem_req), 32'd0);
        tick();
        check("gt_pc",   IF_pc, 32'h0000_3204);
        check("gt_addr", imem_addr, 32'h0000_3208);

        // reset during WAIT; the late response must be ignored
        rsp_en = 1'b0;
        tick();
        rst = 1'b0; rsp_en = 1'b1;
        tick();
        check("mrst_valid", 32'(IF_valid), 32'd0);
        check("mrst_pc4",   IF_pc4, 32'h4);
        check("mrst_req",   32'(imem_req), 32'd0);
        rst = 1'b1;
        tick();
        check("mrst_ignore", 32'(IF_valid), 32'd0);
        check("mrst_addr",   imem_addr, 32'h0000_3000);
        tick(); tick();
        check("mrst_inst", IF_inst, 32'h2408_0005);
        check("mrst_pc",   IF_pc,   32'h0000_3000);

        // redirect coincident with grant, then address wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        check("rg_wait", 32'(imem_req), 32'd0);
        tick();
        check("rg_drop", 32'(IF_valid), 32'd0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); tick();
        check("wrap_pc",    IF_pc,   32'hFFFF_FFFC);
        check("wrap_pc4",   IF_pc4,  32'h0);
        check("wrap_inst",  IF_inst, 32'h2407_D001);
        check("wrap_next",  imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
